// File: rtl/count_seq_checker.sv
// Sink-side sequence checker for a free-running count bus.
// Optional resync-on-mismatch: define COUNT_SEQ_CHECKER_RESYNC_EN.
module count_seq_checker #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] START_VAL   = '0,
  parameter bit               CHECK_START = 1'b1,
  parameter int               ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WIDTH-1:0]     count,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [WIDTH-1:0]     first_bad,
  output logic                 first_bad_vld,
  output logic [WIDTH-1:0]     expected
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]     ONE     = WIDTH'(1);
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_nxt;
  logic             sample;
  logic             mis;
  logic [WIDTH-1:0] exp_nxt;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] exp_inc;

  assign cnt_inc = count + ONE;
  assign exp_inc = expected + ONE;

  // State register; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: enable walks IDLE->ACQ->CHECK, dropping it returns to IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = en ? ACQ : IDLE;
      ACQ:     state_nxt = en ? CHECK : IDLE;
      CHECK:   state_nxt = en ? CHECK : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs of the FSM: lock flag, sample strobe, mismatch and prediction.
  always_comb begin
    locked  = (state == CHECK);
    sample  = 1'b0;
    mis     = 1'b0;
    exp_nxt = expected;
    unique case (state)
      ACQ: begin
        sample  = en;
        mis     = en && CHECK_START
                  && (count != START_VAL);
        exp_nxt = cnt_inc;
      end
      CHECK: begin
        sample = en;
        mis    = en && (count != expected);
`ifdef COUNT_SEQ_CHECKER_RESYNC_EN
        exp_nxt = (count != expected)
                  ? cnt_inc : exp_inc;
`else
        exp_nxt = exp_inc;
`endif
      end
      default: begin
        sample  = 1'b0;
        mis     = 1'b0;
        exp_nxt = expected;
      end
    endcase
  end

  // Registered results: prediction, error pulse, tally, first capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      expected      <= '0;
      err           <= 1'b0;
      err_cnt       <= '0;
      first_bad     <= '0;
      first_bad_vld <= 1'b0;
    end else begin
      err <= mis;
      if (sample) begin
        expected <= exp_nxt;
      end
      if (mis && (err_cnt != CNT_MAX)) begin
        err_cnt <= err_cnt + CNT_ONE;
      end
      if (mis && !first_bad_vld) begin
        first_bad     <= count;
        first_bad_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker.
// Four instances cover start check, wrap, resync and saturation.
module tb_count_seq_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // a: defaults (WIDTH 32, CHECK_START 1)
  logic        a_en = 0;
  logic [31:0] a_count = '0;
  logic        a_locked, a_err, a_vld;
  logic [15:0] a_ecnt;
  logic [31:0] a_fb, a_exp;

  // b: CHECK_START 0, for glitch and enable toggle
  logic        b_en = 0;
  logic [31:0] b_count = '0;
  logic        b_locked, b_err, b_vld;
  logic [15:0] b_ecnt;
  logic [31:0] b_fb, b_exp;

  // c: WIDTH 4, CHECK_START 0, wrap
  logic        c_en = 0;
  logic [3:0]  c_count = '0;
  logic        c_locked, c_err, c_vld;
  logic [15:0] c_ecnt;
  logic [3:0]  c_fb, c_exp;

  // d: ERR_CNT_W 2, WIDTH 8, saturation
  logic        d_en = 0;
  logic [7:0]  d_count = '0;
  logic        d_locked, d_err, d_vld;
  logic [1:0]  d_ecnt;
  logic [7:0]  d_fb, d_exp;

  count_seq_checker u_a (
    .clk(clk), .rst(rst), .en(a_en), .count(a_count),
    .locked(a_locked), .err(a_err), .err_cnt(a_ecnt),
    .first_bad(a_fb), .first_bad_vld(a_vld), .expected(a_exp)
  );

  count_seq_checker #(.CHECK_START(1'b0)) u_b (
    .clk(clk), .rst(rst), .en(b_en), .count(b_count),
    .locked(b_locked), .err(b_err), .err_cnt(b_ecnt),
    .first_bad(b_fb), .first_bad_vld(b_vld), .expected(b_exp)
  );

  count_seq_checker #(.WIDTH(4), .START_VAL(4'd0),
                      .CHECK_START(1'b0)) u_c (
    .clk(clk), .rst(rst), .en(c_en), .count(c_count),
    .locked(c_locked), .err(c_err), .err_cnt(c_ecnt),
    .first_bad(c_fb), .first_bad_vld(c_vld), .expected(c_exp)
  );

  count_seq_checker #(.WIDTH(8), .START_VAL(8'd0),
                      .CHECK_START(1'b0), .ERR_CNT_W(2)) u_d (
    .clk(clk), .rst(rst), .en(d_en), .count(d_count),
    .locked(d_locked), .err(d_err), .err_cnt(d_ecnt),
    .first_bad(d_fb), .first_bad_vld(d_vld), .expected(d_exp)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int npulse;

  initial begin
    // ---- reset state ----
    do_reset();
    check("rst_locked", a_locked, 0);
    check("rst_err", a_err, 0);
    check("rst_ecnt", a_ecnt, 0);
    check("rst_fb", a_fb, 0);
    check("rst_vld", a_vld, 0);
    check("rst_exp", a_exp, 0);

    // ---- clean run: ACQUIRE sample is 0 ----
    a_en = 1; a_count = 0;
    tick();
    check("acq_not_locked", a_locked, 0);
    tick();
    check("acq_locked", a_locked, 1);
    check("acq_exp", a_exp, 1);
    check("acq_err", a_err, 0);
    npulse = 0;
    for (int i = 1; i <= 100; i++) begin
      a_count = 32'(i);
      tick();
      if (a_err) npulse++;
    end
    check("run_pulses", npulse, 0);
    check("run_ecnt", a_ecnt, 0);
    check("run_exp", a_exp, 101);

    // ---- two mismatches then reset mid-CHECK ----
    a_count = 32'd5000;
    tick();
    check("bad1_err", a_err, 1);
    a_count = 32'd6000;
    tick();
    check("bad2_ecnt", a_ecnt, 2);
    check("bad2_fb", a_fb, 5000);
    rst = 1; a_count = 32'd7;
    tick();
    rst = 0;
    check("mrst_locked", a_locked, 0);
    check("mrst_err", a_err, 0);
    check("mrst_ecnt", a_ecnt, 0);
    check("mrst_vld", a_vld, 0);
    check("mrst_exp", a_exp, 0);
    a_en = 0;
    tick();

    // ---- start check: first acquired sample 3 ----
    do_reset();
    a_en = 1; a_count = 3;
    tick();
    tick();
    check("start_err", a_err, 1);
    check("start_fb", a_fb, 3);
    check("start_vld", a_vld, 1);
    check("start_exp", a_exp, 4);
    a_count = 4;
    tick();
    check("start_next_err", a_err, 0);
    check("start_ecnt", a_ecnt, 1);
    a_en = 0;

    // ---- single glitch 5,6,9,10,11 ----
    do_reset();
    b_en = 1; b_count = 5;
    tick();
    tick();
    check("gl_exp5", b_exp, 6);
    b_count = 6;
    tick();
    check("gl_err6", b_err, 0);
    b_count = 9;
    tick();
    check("gl_err9", b_err, 1);
    check("gl_fb", b_fb, 9);
    check("gl_vld", b_vld, 1);
    b_count = 10;
    tick();
`ifdef COUNT_SEQ_CHECKER_RESYNC_EN
    check("gl_err10", b_err, 0);
`else
    check("gl_err10", b_err, 1);
`endif
    b_count = 11;
    tick();
`ifdef COUNT_SEQ_CHECKER_RESYNC_EN
    check("gl_err11", b_err, 0);
    check("gl_ecnt", b_ecnt, 1);
    check("gl_exp", b_exp, 12);
`else
    check("gl_err11", b_err, 1);
    check("gl_ecnt", b_ecnt, 3);
    check("gl_exp", b_exp, 10);
`endif
    check("gl_fb_hold", b_fb, 9);

    // ---- enable drop and reacquire ----
    b_en = 0; b_count = 12;
    tick();
    check("dis_locked", b_locked, 0);
    check("dis_err", b_err, 0);
`ifdef COUNT_SEQ_CHECKER_RESYNC_EN
    check("dis_exp_hold", b_exp, 12);
`else
    check("dis_exp_hold", b_exp, 10);
`endif
    b_en = 1; b_count = 50;
    tick();
    tick();
    check("reacq_locked", b_locked, 1);
    check("reacq_err", b_err, 0);
    check("reacq_exp", b_exp, 51);
    b_count = 51;
    tick();
    check("reacq_err2", b_err, 0);
    check("reacq_vld", b_vld, 1);
    check("reacq_fb", b_fb, 9);
    b_en = 0;

    // ---- wrap-around on 4 bits ----
    do_reset();
    c_en = 1; c_count = 13;
    tick();
    tick();
    npulse = 0;
    c_count = 14; tick(); if (c_err) npulse++;
    c_count = 15; tick(); if (c_err) npulse++;
    check("wrap_exp0", c_exp, 0);
    c_count = 0;  tick(); if (c_err) npulse++;
    c_count = 1;  tick(); if (c_err) npulse++;
    check("wrap_pulses", npulse, 0);
    check("wrap_exp2", c_exp, 2);
    check("wrap_ecnt", c_ecnt, 0);
    c_en = 0;

    // ---- saturation with ERR_CNT_W 2 ----
    do_reset();
    d_en = 1; d_count = 0;
    tick();
    tick();
    check("sat_acq_err", d_err, 0);
    npulse = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (d_err) npulse++;
      if (i == 2) check("sat_ecnt2", d_ecnt, 2);
    end
    check("sat_pulses", npulse, 10);
    check("sat_ecnt", d_ecnt, 3);
    check("sat_err", d_err, 1);
    check("sat_fb", d_fb, 0);
    check("sat_vld", d_vld, 1);
    d_en = 0;
    tick();
    check("sat_idle_err", d_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
